// File: rtl/wb_pkg.sv
// Shared request type and default widths for the register-file writeback path.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 6;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational dual round-robin picker: port 1 takes the first pending slot from rr_ptr,
// port 2 the next pending slot whose address differs; same-address slots wait a cycle.
module wb_rr_pick2 #(
  parameter int NUM_SRC    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int PTR_W      = 2
) (
  input  logic [NUM_SRC-1:0]            pending,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] addr,
  input  logic [PTR_W-1:0]              rr_ptr,
  output logic [NUM_SRC-1:0]            grant1,
  output logic [NUM_SRC-1:0]            grant2,
  output logic                          vld1,
  output logic                          vld2,
  output logic                          conflict,
  output logic [PTR_W-1:0]              rr_ptr_nxt
);

  logic [PTR_W:0]          pos;
  logic [PTR_W-1:0]        idx;
  logic [PTR_W-1:0]        last;
  logic [ADDR_WIDTH-1:0]   addr1;

  always_comb begin
    grant1     = '0;
    grant2     = '0;
    vld1       = 1'b0;
    vld2       = 1'b0;
    conflict   = 1'b0;
    addr1      = '0;
    last       = rr_ptr;
    pos        = '0;
    idx        = '0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_SRC))
        pos = pos - (PTR_W+1)'(NUM_SRC);
      idx = pos[PTR_W-1:0];
      if (pending[idx]) begin
        if (!vld1) begin
          vld1        = 1'b1;
          grant1[idx] = 1'b1;
          addr1       = addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
          last        = idx;
        end else if (!vld2) begin
          // Skipped slot stays pending so the earlier-scanned result commits first.
          if (addr[idx*ADDR_WIDTH +: ADDR_WIDTH] != addr1) begin
            vld2        = 1'b1;
            grant2[idx] = 1'b1;
            last        = idx;
          end else begin
            conflict = 1'b1;
          end
        end
      end
    end
    if (vld1) begin
      if (last == PTR_W'(NUM_SRC-1))
        rr_ptr_nxt = '0;
      else
        rr_ptr_nxt = last + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Collects NUM_SRC results into one-entry slots and drives two registered write ports (accept->drive 1 cycle).
// src_ready = slot free or granted this cycle, held low during flush. WB_ARB_STATS_EN adds conflict/grant counters.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ADDR_WIDTH = WB_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic                          write_En,
  output logic [ADDR_WIDTH-1:0]         write_Addr,
  output logic [DATA_WIDTH-1:0]         write_Data,
  output logic                          write_En_2,
  output logic [ADDR_WIDTH-1:0]         write_Addr_2,
  output logic [DATA_WIDTH-1:0]         write_Data_2,
  output logic                          idle
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]                   conflict_cnt,
  output logic [31:0]                   grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            slot_valid;
  logic [NUM_SRC*ADDR_WIDTH-1:0] slot_addr;
  logic [NUM_SRC*DATA_WIDTH-1:0] slot_data;
  logic [NUM_SRC-1:0]            grant1, grant2, grant;
  logic                          vld1, vld2, conflict;
  logic [PTR_W-1:0]              rr_ptr, rr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]         pick_addr1, pick_addr2;
  logic [DATA_WIDTH-1:0]         pick_data1, pick_data2;

  wb_rr_pick2 #(
    .NUM_SRC    (NUM_SRC),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PTR_W      (PTR_W)
  ) u_pick (
    .pending    (slot_valid),
    .addr       (slot_addr),
    .rr_ptr     (rr_ptr),
    .grant1     (grant1),
    .grant2     (grant2),
    .vld1       (vld1),
    .vld2       (vld2),
    .conflict   (conflict),
    .rr_ptr_nxt (rr_ptr_nxt)
  );

  assign grant     = grant1 | grant2;
  assign src_ready = flush ? '0 : (~slot_valid | grant);
  assign idle      = ~(|slot_valid) & ~write_En & ~write_En_2;

  always_comb begin
    pick_addr1 = '0;
    pick_data1 = '0;
    pick_addr2 = '0;
    pick_data2 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant1[i]) begin
        pick_addr1 = slot_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_data1 = slot_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant2[i]) begin
        pick_addr2 = slot_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_data2 = slot_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 results are consumed but never occupy a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_addr  <= '0;
      slot_data  <= '0;
    end else if (flush) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          slot_valid[i]                           <= |src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_addr[i*ADDR_WIDTH +: ADDR_WIDTH]   <= src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data[i*DATA_WIDTH +: DATA_WIDTH]   <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_En     <= 1'b0;
      write_Addr   <= '0;
      write_Data   <= '0;
      write_En_2   <= 1'b0;
      write_Addr_2 <= '0;
      write_Data_2 <= '0;
      rr_ptr       <= '0;
    end else if (flush) begin
      write_En   <= 1'b0;
      write_En_2 <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      write_En   <= vld1;
      write_En_2 <= vld2;
      rr_ptr     <= rr_ptr_nxt;
      if (vld1) begin
        write_Addr <= pick_addr1;
        write_Data <= pick_data1;
      end
      if (vld2) begin
        write_Addr_2 <= pick_addr2;
        write_Data_2 <= pick_data2;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      grant_cnt    <= '0;
    end else if (flush) begin
      conflict_cnt <= '0;
      grant_cnt    <= '0;
    end else begin
      if (conflict && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
      grant_cnt <= grant_cnt + 32'(vld1) + 32'(vld2);
    end
  end
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule
